// File: rtl/timekeeper_core.sv
// timekeeper_core
// Time-of-day clock plus stopwatch, both kept as h:m:s.cs counters, driving
// the binary fields consumed by the 7-segment decode stage.
//
// Parameters:
//   TICK_DIV    clock cycles per centisecond (>= 2)
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   mode        display select: 0 = time of day, 1 = stopwatch
//   start_stop  stopwatch start/pause pulse
//   clear       stopwatch clear pulse
//   set_en      time-of-day set mode (level, only while mode = 0)
//   set_sel     field to set: 0 = minutes, 1 = hours
//   inc         increment pulse for the selected field
//   mili        centiseconds of the displayed bank (0..99)
//   seg         seconds (0..59)
//   min         minutes (0..59)
//   hour        hours (0..23)
//   running     high while the stopwatch is in RUN
module timekeeper_core #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       set_en,
  input  logic       set_sel,
  input  logic       inc,
  output logic [6:0] mili,
  output logic [5:0] seg,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] cs;
  } hms_t;

  localparam hms_t HMS_MAX = '{h: 5'd23, m: 6'd59, s: 6'd59, cs: 7'd99};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // One-centisecond step with cascade carries; 23:59:59.99 wraps to zero.
  function automatic hms_t advance(input hms_t t);
    hms_t n;
    n = t;
    if (t.cs != 7'd99) begin
      n.cs = t.cs + 7'd1;
    end else begin
      n.cs = '0;
      if (t.s != 6'd59) begin
        n.s = t.s + 6'd1;
      end else begin
        n.s = '0;
        if (t.m != 6'd59) begin
          n.m = t.m + 6'd1;
        end else begin
          n.m = '0;
          n.h = (t.h == 5'd23) ? 5'd0 : t.h + 5'd1;
        end
      end
    end
    return n;
  endfunction

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          setting;
  hms_t          tod;
  hms_t          sw_time;
  sw_state_t     state;

  assign tick    = (pcnt == PW'(TICK_DIV - 1));
  // Set mode only exists on the time-of-day display.
  assign setting = set_en && !mode;

  // Shared prescaler, free-running; only rst clears it.
  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Time-of-day bank. Set mode freezes counting, so an inc coinciding with
  // a tick wins and the tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod <= '0;
    end else if (setting) begin
      tod.s  <= '0;
      tod.cs <= '0;
      if (inc) begin
        if (set_sel) begin
          tod.h <= (tod.h == 5'd23) ? 5'd0 : tod.h + 5'd1;
        end else begin
          tod.m <= (tod.m == 6'd59) ? 6'd0 : tod.m + 6'd1;
        end
      end
    end else if (tick) begin
      tod <= advance(tod);
    end
  end

  // Stopwatch FSM with its counter and the registered running flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sw_time <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sw_time <= '0;
          // clear wins over a simultaneous start
          if (start_stop && !clear) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            // Saturate at the top value instead of wrapping.
            if (sw_time == HMS_MAX) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              sw_time <= advance(sw_time);
            end
          end
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (clear) begin
            state   <= IDLE;
            sw_time <= '0;
          end else if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          sw_time <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Unregistered display mux so a mode change shows up in the same cycle.
  assign mili = mode ? sw_time.cs : tod.cs;
  assign seg  = mode ? sw_time.s  : tod.s;
  assign min  = mode ? sw_time.m  : tod.m;
  assign hour = mode ? sw_time.h  : tod.h;

endmodule

// File: tb/tb_timekeeper_core.sv
// Testbench for timekeeper_core: directed stimulus, a behavioural model that
// keeps both banks as plain centisecond totals, a per-cycle compare process
// and literal expectations at the key points.
module tb_timekeeper_core;

  localparam int TICK_DIV = 4;
  localparam int DAY      = 24 * 60 * 60 * 100;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       start_stop;
  logic       clear;
  logic       set_en;
  logic       set_sel;
  logic       inc;
  logic [6:0] mili;
  logic [5:0] seg;
  logic [5:0] minute;
  logic [4:0] hour;
  logic       running;

  int passed;
  int total;
  logic preload_req;

  timekeeper_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .start_stop(start_stop),
    .clear     (clear),
    .set_en    (set_en),
    .set_sel   (set_sel),
    .inc       (inc),
    .mili      (mili),
    .seg       (seg),
    .min       (minute),
    .hour      (hour),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int pcnt;
    int tod;    // centiseconds since midnight
    int sw;     // stopwatch centiseconds
    int st;
    int ticks;  // number of prescaler ticks seen since reset
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t c, input logic md,
                                        input logic ss, input logic cl,
                                        input logic se, input logic sel,
                                        input logic in, input logic pre);
    model_t n;
    bit tk;
    int h;
    int mi;
    int sw;
    n       = c;
    tk      = (c.pcnt == TICK_DIV - 1);
    n.pcnt  = (c.pcnt + 1) % TICK_DIV;
    if (tk) n.ticks = c.ticks + 1;
    if (se && !md) begin
      h  = c.tod / 360000;
      mi = (c.tod / 6000) % 60;
      if (in) begin
        if (sel) h = (h + 1) % 24;
        else     mi = (mi + 1) % 60;
      end
      n.tod = h * 360000 + mi * 6000;
    end else if (tk) begin
      n.tod = (c.tod + 1) % DAY;
    end
    sw   = pre ? DAY - 2 : c.sw;
    n.sw = sw;
    case (c.st)
      M_IDLE: begin
        n.sw = 0;
        if (!cl && ss) n.st = M_RUN;
      end
      M_RUN: begin
        if (tk) begin
          if (sw == DAY - 1) n.st = M_PAUSE;
          else               n.sw = sw + 1;
        end
        if (ss) n.st = M_PAUSE;
      end
      default: begin
        if (cl) begin
          n.st = M_IDLE;
          n.sw = 0;
        end else if (ss) begin
          n.st = M_RUN;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{pcnt: 0, tod: 0, sw: 0, st: M_IDLE, ticks: 0};
    else     m <= model_step(m, mode, start_stop, clear, set_en, set_sel, inc, preload_req);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mili", int'(mili), (mode ? m.sw : m.tod) % 100);
    check("seg",  int'(seg),  ((mode ? m.sw : m.tod) / 100) % 60);
    check("min",  int'(minute), ((mode ? m.sw : m.tod) / 6000) % 60);
    check("hour", int'(hour), (mode ? m.sw : m.tod) / 360000);
    check("running", int'(running), int'(m.st == M_RUN));
  end

  // -------------------------------------------------------------- helpers
  task automatic pulse(input logic ss, input logic cl, input logic in);
    start_stop = ss;
    clear      = cl;
    inc        = in;
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    inc        = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_ticks(input int n);
    int base;
    int guard;
    base  = m.ticks;
    guard = 0;
    while (m.ticks < base + n && guard < n * TICK_DIV + 8) begin
      @(negedge clk);
      guard++;
    end
    if (m.ticks < base + n) check("tick_timeout", m.ticks - base, n);
  endtask

  task automatic expect_time(input string name, input int h, input int mi,
                             input int s, input int cs);
    check({name, "_hour"}, int'(hour), h);
    check({name, "_min"},  int'(minute), mi);
    check({name, "_seg"},  int'(seg), s);
    check({name, "_mili"}, int'(mili), cs);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    mode        = 1'b0;
    start_stop  = 1'b0;
    clear       = 1'b0;
    set_en      = 1'b0;
    set_sel     = 1'b0;
    inc         = 1'b0;
    preload_req = 1'b0;

    // Reset and first tick
    repeat (2) @(negedge clk);
    expect_time("reset", 0, 0, 0, 0);
    check("reset_running", int'(running), 0);
    rst = 1'b0;
    for (int i = 0; i < TICK_DIV - 1; i++) begin
      @(negedge clk);
      check("pre_first_tick_mili", int'(mili), 0);
    end
    @(negedge clk);
    check("first_tick_mili", int'(mili), 1);

    // Set to 23:59, then roll over after 6000 ticks
    set_en  = 1'b1;
    set_sel = 1'b1;
    incs(23);
    set_sel = 1'b0;
    incs(59);
    expect_time("set_2359", 23, 59, 0, 0);
    set_en = 1'b0;
    wait_ticks(6000);
    expect_time("rollover", 0, 0, 0, 0);

    // Set wrap
    set_en  = 1'b1;
    set_sel = 1'b1;
    incs(24);
    check("hour_wrap", int'(hour), 0);
    incs(5);
    check("hour_5", int'(hour), 5);
    set_sel = 1'b0;
    incs(59);
    check("min_59", int'(minute), 59);
    incs(1);
    check("min_wrap", int'(minute), 0);
    check("min_wrap_hour", int'(hour), 5);
    // inc ignored while the stopwatch is displayed
    mode = 1'b1;
    incs(3);
    mode = 1'b0;
    #1 check("inc_ignored_mode1", int'(minute), 0);
    @(negedge clk);
    set_en = 1'b0;

    // Stopwatch FSM
    mode = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    wait_ticks(150);
    pulse(1'b1, 1'b0, 1'b0);
    expect_time("sw_150", 0, 0, 1, 50);
    check("sw_paused", int'(running), 0);
    wait_ticks(3);
    expect_time("sw_held", 0, 0, 1, 50);
    pulse(1'b0, 1'b1, 1'b0);
    expect_time("sw_clear", 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_ticks(5);
    pulse(1'b0, 1'b1, 1'b0);
    check("clear_in_run_running", int'(running), 1);
    check("clear_in_run_mili", int'(mili), 5);

    // Simultaneous pulses
    pulse(1'b1, 1'b1, 1'b0);
    check("both_in_run_running", int'(running), 0);
    check("both_in_run_mili", int'(mili), 5);
    pulse(1'b1, 1'b1, 1'b0);
    expect_time("both_in_pause", 0, 0, 0, 0);
    check("both_in_pause_running", int'(running), 0);

    // Saturation while the time of day is displayed
    mode = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    #2;
    force dut.sw_time = {5'd23, 6'd59, 6'd59, 7'd98};
    preload_req = 1'b1;
    #1;
    release dut.sw_time;
    @(negedge clk);
    preload_req = 1'b0;
    wait_ticks(3);
    mode = 1'b1;
    #1;
    expect_time("saturate", 23, 59, 59, 99);
    check("saturate_running", int'(running), 0);
    @(negedge clk);
    mode = 1'b0;

    // Reset mid-operation
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    expect_time("mid_reset", 0, 0, 0, 0);
    check("mid_reset_running", int'(running), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timekeeper_core.md
# timekeeper_core

Timekeeping stage for the digital clock/stopwatch. It holds a time-of-day counter and a stopwatch counter, both in centiseconds, seconds, minutes and hours, and handles start/stop/clear and time setting. It drives the binary fields (`mili`, `seg`, `min`, `hour`) consumed by the 7-segment decode stage directly downstream. Button inputs arrive already debounced and edge-detected as single-cycle pulses.

## Interface
- `TICK_DIV`, default 500000: clock cycles per centisecond (50 MHz / 100). Minimum value 2.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 1: display select. 0 = time of day, 1 = stopwatch.
- `start_stop` input 1: stopwatch start/pause pulse.
- `clear` input 1: stopwatch clear pulse.
- `set_en` input 1: level. Time-of-day set mode. Only effective while `mode`=0.
- `set_sel` input 1: field to set. 0 = minutes, 1 = hours.
- `inc` input 1: increment pulse for the selected field.
- `mili` output 7: centiseconds of the selected bank, 0–99.
- `seg` output 6: seconds, 0–59.
- `min` output 6: minutes, 0–59.
- `hour` output 5: hours, 0–23.
- `running` output 1: high while the stopwatch is in RUN.

## Operation
- **Prescaler**
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted internally in the cycle the count equals TICK_DIV-1.
  - A single prescaler is shared by both banks. It is never cleared except by `rst`.
- **Time-of-day bank (tod)**
  - On `tick`, when not setting, the bank advances with cascade carries: cs 99→0 carries to s, s 59→0 to m, m 59→0 to h, h 23→0.
  - 23:59:59.99 followed by a tick gives 00:00:00.00.
- **Set mode**
  - Active when `set_en`=1 and `mode`=0.
  - tod ignores `tick`; s and cs are forced to 0.
  - `inc` increments the selected field by 1, without carry. Minutes wrap 59→0; hours wrap 23→0.
  - When `set_en` falls, counting resumes from the set value at the next `tick`.
- **Stopwatch bank (sw)**
  - FSM states: IDLE, RUN, PAUSE.
  - IDLE: all sw fields are 0. `start_stop` → RUN.
  - RUN: sw advances on `tick` using the same cascade as tod. `start_stop` → PAUSE. `clear` is ignored.
  - PAUSE: sw is held. `start_stop` → RUN. `clear` → IDLE, zeroing all fields.
  - `start_stop` and `clear` together: in RUN the result is PAUSE; in PAUSE or IDLE the result is IDLE (clear wins).
  - Saturation: if sw is 23:59:59.99 and a tick occurs in RUN, the value holds and the FSM goes to PAUSE.
  - The stopwatch operates regardless of `mode`; it keeps counting while tod is displayed.
- **Output mux**
  - Outputs show the tod fields when `mode`=0 and the sw fields when `mode`=1.
  - The mux is combinational from the bank registers, with no added register.
- **Unused input combinations**
  - `inc` is ignored when `set_en`=0 or `mode`=1.
  - `set_en` is treated as 0 while `mode`=1, so tod keeps counting.

## Timing
- **Reset**
  - Assertion immediately forces the prescaler to 0, tod to 00:00:00.00, sw to 0, FSM to IDLE, and `running`=0.
  - All outputs therefore read 0.
  - Reset applied mid-operation has the same effect; no state is retained.
- **After reset release:** the first tod increment to cs=1 occurs at the TICK_DIV-th rising edge.
- **Bank updates:** all counter updates occur at the rising edge of the cycle in which `tick` is asserted. Outputs change in the same cycle as the register update.
- **Pulse inputs:** `start_stop`, `clear` and `inc` are sampled at the rising edge. The state or field change is visible after that edge (1-cycle latency). `running` follows the FSM state with the same latency.
- **Start latency:** a start begins counting at the next shared tick, between 1 and TICK_DIV cycles later.
- **`inc` coinciding with `tick`:** `inc` is applied and the tick is ignored, because set mode freezes tod.
- **`mode` changes:** outputs switch in the same cycle; no state changes.

## Test plan
- **Reset and first tick:** TICK_DIV=4; release `rst` and run 4 cycles → `mili`=1. All outputs are 0 before that edge.
- **Tod rollover:** set tod to 23:59 with `set_en`, with s and cs at 0, then release `set_en` and run 6000 ticks → outputs 00:00:00.00 with `hour`=0.
- **Set wrap:** `set_en`=1, `set_sel`=1, 24 `inc` pulses → `hour` returns to its start value. With `set_sel`=0 at `min`=59, one `inc` → `min`=0 and `hour` unchanged.
- **Stopwatch FSM:** `mode`=1; `start_stop`, 150 ticks, `start_stop` → 00:00:01.50 held with `running`=0. `clear` → all 0. `clear` during RUN → no effect.
- **Simultaneous pulses:** in PAUSE, `start_stop` and `clear` in the same cycle → IDLE, all 0, `running`=0. In RUN, the same pair → PAUSE.
- **Saturation and background run:** force sw to 23:59:59.98 in RUN with `mode`=0, then 2 ticks → `mode`=1 shows 23:59:59.99 and `running`=0. Throughout, tod keeps counting.
